// File: rtl/plic_target_ctrl.sv
// Target-side PLIC claim/complete sequencer: claims the core's pending ID, hands it
// to a hardware consumer, waits for service, then completes and lets the core settle.
module plic_target_ctrl #(
  parameter int unsigned IRQ_WIDTH  = 5,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TMO_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 irq_i,
  input  logic [IRQ_WIDTH-1:0] id_i,
  output logic                 clam_o,
  output logic                 comp_o,
  output logic [IRQ_WIDTH-1:0] comp_id_o,
  output logic                 vld_o,
  output logic [IRQ_WIDTH-1:0] id_o,
  input  logic                 rdy_i,
  input  logic                 done_i,
  input  logic [IRQ_WIDTH-1:0] done_id_i,
  input  logic [TMO_WIDTH-1:0] tmo_i,
  output logic                 busy_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  localparam int unsigned SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLAIM    = 3'd1,
    S_PRESENT  = 3'd2,
    S_SERVICE  = 3'd3,
    S_COMPLETE = 3'd4,
    S_SETTLE   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [IRQ_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic                 id_match;
  logic                 done_match;
  logic                 tmo_hit;

  assign id_match   = (id_i == cur_id_q);
  assign done_match = done_i && (done_id_i == cur_id_q);
  assign tmo_hit    = (tmo_i != '0) && (tmo_q == (tmo_i - TMO_WIDTH'(1)));

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cur_id_q <= '0;
      tmo_q    <= '0;
      set_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      tmo_q    <= tmo_d;
      set_q    <= set_d;
      err_q    <= err_d;
    end
  end

  // Next-state, counters and error flag
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    tmo_d    = tmo_q;
    set_d    = set_q;
    err_set  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en_i && irq_i && (id_i != '0)) begin
          cur_id_d = id_i;
          state_d  = S_CLAIM;
        end
      end
      // A changed id_i means the core re-arbitrated; drop back without claiming
      S_CLAIM: begin
        state_d = id_match ? S_PRESENT : S_IDLE;
      end
      S_PRESENT: begin
        if (rdy_i) begin
          tmo_d   = '0;
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (tmo_q != '1) begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
        if (done_match) begin
          state_d = S_COMPLETE;
        end else begin
          if (done_i) begin
            err_set = 1'b1;
          end
          if (tmo_hit) begin
            err_set = 1'b1;
            state_d = S_COMPLETE;
          end
        end
      end
      S_COMPLETE: begin
        set_d   = SET_W'(SETTLE_CYC);
        state_d = (SETTLE_CYC == 0) ? S_IDLE : S_SETTLE;
      end
      S_SETTLE: begin
        set_d = set_q - SET_W'(1);
        if (set_q <= SET_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Claim is combinational so it aligns with the core's id_o==i gating
  assign clam_o    = (state_q == S_CLAIM) && id_match;
  assign vld_o     = (state_q == S_PRESENT);
  assign id_o      = vld_o ? cur_id_q : '0;
  assign comp_o    = (state_q == S_COMPLETE);
  assign comp_id_o = comp_o ? cur_id_q : '0;
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Directed bench for plic_target_ctrl with hand-derived cycle-by-cycle expectations.
module tb_plic_target_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, irq, rdy, done, err_clr;
  logic [4:0]  id, done_id;
  logic [15:0] tmo;
  logic        clam, comp, vld, busy, err;
  logic [4:0]  comp_id, id_out;

  int checks = 0;
  int passed = 0;

  plic_target_ctrl #(.IRQ_WIDTH(5), .SETTLE_CYC(2), .TMO_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .irq_i(irq), .id_i(id),
    .clam_o(clam), .comp_o(comp), .comp_id_o(comp_id), .vld_o(vld), .id_o(id_out),
    .rdy_i(rdy), .done_i(done), .done_id_i(done_id), .tmo_i(tmo),
    .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; irq = 1'b0; id = '0; rdy = 1'b0;
    done = 1'b0; done_id = '0; tmo = '0; err_clr = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else passed++;
    checks++; if (clam !== 1'b0) $display("FAIL rst_clam got %0b exp 0", clam); else passed++;
    checks++; if (vld !== 1'b0 || id_out !== 5'd0) $display("FAIL rst_vld got %0b/%0d exp 0/0", vld, id_out); else passed++;
    checks++; if (comp !== 1'b0 || comp_id !== 5'd0) $display("FAIL rst_comp got %0b/%0d exp 0/0", comp, comp_id); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err got %0b exp 0", err); else passed++;
    tick();
    rst = 1'b0;
    en = 1'b1; irq = 1'b1; id = 5'd0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL id0_ignored busy got %0b exp 0", busy); else passed++;
    en = 1'b0; id = 5'd7;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL en0_ignored busy got %0b exp 0", busy); else passed++;
    irq = 1'b0; id = '0;
  endtask

  task automatic test_basic;
    en = 1'b1; irq = 1'b1; id = 5'd7; rdy = 1'b1; tmo = '0;
    tick();
    checks++; if (clam !== 1'b1) $display("FAIL basic_clam got %0b exp 1", clam); else passed++;
    tick();
    checks++; if (vld !== 1'b1 || id_out !== 5'd7) $display("FAIL basic_vld got %0b/%0d exp 1/7", vld, id_out); else passed++;
    checks++; if (clam !== 1'b0) $display("FAIL basic_clam_pulse got %0b exp 0", clam); else passed++;
    tick();
    checks++; if (vld !== 1'b0 || id_out !== 5'd0 || busy !== 1'b1) $display("FAIL basic_service got vld %0b id %0d busy %0b exp 0/0/1", vld, id_out, busy); else passed++;
    tick();
    checks++; if (comp !== 1'b0) $display("FAIL basic_no_early_comp got %0b exp 0", comp); else passed++;
    done = 1'b1; done_id = 5'd7;
    tick();
    checks++; if (comp !== 1'b1 || comp_id !== 5'd7) $display("FAIL basic_comp got %0b/%0d exp 1/7", comp, comp_id); else passed++;
    done = 1'b0; irq = 1'b0; id = '0;
    tick();
    checks++; if (comp !== 1'b0 || comp_id !== 5'd0 || busy !== 1'b1) $display("FAIL basic_settle1 got comp %0b id %0d busy %0b exp 0/0/1", comp, comp_id, busy); else passed++;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL basic_settle2 busy got %0b exp 1", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL basic_idle got busy %0b err %0b exp 0/0", busy, err); else passed++;
  endtask

  task automatic test_rearb;
    irq = 1'b1; id = 5'd3; rdy = 1'b1;
    tick();
    id = 5'd9;
    #1;
    checks++; if (clam !== 1'b0) $display("FAIL rearb_noclaim got %0b exp 0", clam); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL rearb_idle busy got %0b exp 0", busy); else passed++;
    tick();
    checks++; if (clam !== 1'b1) $display("FAIL rearb_claim9 got %0b exp 1", clam); else passed++;
    tick();
    checks++; if (vld !== 1'b1 || id_out !== 5'd9) $display("FAIL rearb_vld got %0b/%0d exp 1/9", vld, id_out); else passed++;
    done = 1'b1; done_id = 5'd9;
    tick(2);
    checks++; if (comp !== 1'b1 || comp_id !== 5'd9) $display("FAIL rearb_comp got %0b/%0d exp 1/9", comp, comp_id); else passed++;
    done = 1'b0; irq = 1'b0; id = '0;
    tick(3);
    checks++; if (busy !== 1'b0) $display("FAIL rearb_end busy got %0b exp 0", busy); else passed++;
  endtask

  task automatic test_timeout;
    tmo = 16'd10; irq = 1'b1; id = 5'd12; rdy = 1'b1;
    tick(2);
    irq = 1'b0; id = '0;
    tick();
    tick(9);
    checks++; if (comp !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_early got comp %0b busy %0b exp 0/1", comp, busy); else passed++;
    tick();
    checks++; if (comp !== 1'b1 || comp_id !== 5'd12) $display("FAIL tmo_comp got %0b/%0d exp 1/12", comp, comp_id); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL tmo_err got %0b exp 1", err); else passed++;
    tmo = '0;
    tick(3);
    checks++; if (busy !== 1'b0 || err !== 1'b1) $display("FAIL tmo_sticky got busy %0b err %0b exp 0/1", busy, err); else passed++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) $display("FAIL tmo_errclr got %0b exp 0", err); else passed++;
  endtask

  task automatic test_mismatch;
    irq = 1'b1; id = 5'd5; rdy = 1'b1;
    tick(2);
    irq = 1'b0; id = '0;
    tick();
    done = 1'b1; done_id = 5'd4; err_clr = 1'b1;
    tick();
    checks++; if (err !== 1'b1) $display("FAIL mism_err_setwins got %0b exp 1", err); else passed++;
    checks++; if (comp !== 1'b0 || busy !== 1'b1) $display("FAIL mism_stay got comp %0b busy %0b exp 0/1", comp, busy); else passed++;
    done = 1'b0; err_clr = 1'b0;
    tick();
    checks++; if (comp !== 1'b0 || err !== 1'b1) $display("FAIL mism_hold got comp %0b err %0b exp 0/1", comp, err); else passed++;
    done = 1'b1; done_id = 5'd5;
    tick();
    checks++; if (comp !== 1'b1 || comp_id !== 5'd5) $display("FAIL mism_comp got %0b/%0d exp 1/5", comp, comp_id); else passed++;
    done = 1'b0;
    tick(3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL mism_end got err %0b busy %0b exp 0/0", err, busy); else passed++;
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    tmo = 16'd3; rdy = 1'b0; irq = 1'b1; id = 5'd6;
    tick(2);
    irq = 1'b0; id = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vld !== 1'b1 || id_out !== 5'd6 || comp !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL stall_hold bad cycles got %0d exp 0", bad); else passed++;
    rdy = 1'b1; done = 1'b1; done_id = 5'd6;
    tick();
    checks++; if (vld !== 1'b0 || busy !== 1'b1) $display("FAIL stall_accept got vld %0b busy %0b exp 0/1", vld, busy); else passed++;
    tick();
    checks++; if (comp !== 1'b1 || comp_id !== 5'd6 || err !== 1'b0) $display("FAIL stall_comp got %0b/%0d err %0b exp 1/6/0", comp, comp_id, err); else passed++;
    done = 1'b0; tmo = '0;
    tick(3);
    checks++; if (busy !== 1'b0) $display("FAIL stall_end busy got %0b exp 0", busy); else passed++;
  endtask

  task automatic test_async_reset;
    irq = 1'b1; id = 5'd11; rdy = 1'b1;
    tick(2);
    irq = 1'b0; id = '0;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL arst_pre busy got %0b exp 1", busy); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || vld !== 1'b0 || comp !== 1'b0 || clam !== 1'b0) $display("FAIL arst_now got busy %0b vld %0b comp %0b clam %0b exp 0", busy, vld, comp, clam); else passed++;
    tick(2);
    checks++; if (comp !== 1'b0 || comp_id !== 5'd0) $display("FAIL arst_nocomp got %0b/%0d exp 0/0", comp, comp_id); else passed++;
    rst = 1'b0;
    irq = 1'b1; id = 5'd2;
    tick();
    checks++; if (clam !== 1'b1) $display("FAIL arst_claim2 got %0b exp 1", clam); else passed++;
    tick();
    checks++; if (vld !== 1'b1 || id_out !== 5'd2) $display("FAIL arst_vld got %0b/%0d exp 1/2", vld, id_out); else passed++;
    irq = 1'b0; id = '0; done = 1'b1; done_id = 5'd2;
    tick(2);
    checks++; if (comp !== 1'b1 || comp_id !== 5'd2) $display("FAIL arst_comp got %0b/%0d exp 1/2", comp, comp_id); else passed++;
    done = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0) $display("FAIL arst_end busy got %0b exp 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rearb();
    test_timeout();
    test_mismatch();
    test_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

endmodule
